// File: rtl/booth_mult_seq_pkg.sv
// Shared widths and FSM state encodings for the iterative Booth multiplier.
// No logic; imported by the multiplier datapath and controller.
// Constants only.
package booth_mult_seq_pkg;
  localparam int OPERAND_W    = 8;
  localparam int PRODUCT_W    = 16;
  localparam int BOOTH_DIGITS = 5;
  localparam int IDX_W        = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;
endpackage

// File: rtl/booth_encoder.sv
// Radix-4 Booth recoder for an 8-bit multiplier into 5 digits (single/double/negative).
// Combinational, zero latency.
// No handshake; outputs follow the inputs.
module booth_encoder
  import booth_mult_seq_pkg::*;
(
  input  logic [OPERAND_W-1:0]    multiplier,
  input  logic                    signed_mpy,
  output logic [BOOTH_DIGITS-1:0] sel_single,
  output logic [BOOTH_DIGITS-1:0] sel_double,
  output logic [BOOTH_DIGITS-1:0] sel_neg
);
  logic       ext_bit;
  logic [2*BOOTH_DIGITS:0] ext;

  // Two extension bits plus the implicit zero below bit 0 give 5 overlapping triplets.
  assign ext_bit = signed_mpy & multiplier[OPERAND_W-1];
  assign ext     = {ext_bit, ext_bit, multiplier, 1'b0};

  always_comb begin
    sel_single = '0;
    sel_double = '0;
    sel_neg    = '0;
    for (int i = 0; i < BOOTH_DIGITS; i++) begin
      sel_single[i] = ext[2*i+1] ^ ext[2*i];
      sel_double[i] = (ext[2*i+2 -: 3] == 3'b011) || (ext[2*i+2 -: 3] == 3'b100);
      sel_neg[i]    = ext[2*i+2];
    end
  end
endmodule

// File: rtl/booth_mult_seq_pp_gen.sv
// Selects, conditionally negates and positions one Booth partial product.
// Combinational, zero latency.
// No handshake.
module booth_pp_gen
  import booth_mult_seq_pkg::*;
(
  input  logic [PRODUCT_W-1:0] m,
  input  logic                 sel_single,
  input  logic                 sel_double,
  input  logic                 sel_neg,
  input  logic [IDX_W-1:0]     idx,
  output logic [PRODUCT_W-1:0] pp
);
  logic [PRODUCT_W-1:0] mag;
  logic [PRODUCT_W-1:0] signed_pp;

  always_comb begin
    mag = '0;
    if (sel_single)      mag = m;
    else if (sel_double) mag = m << 1;
  end

  // ~0 + 1 wraps to 0, so a negative-zero digit contributes nothing.
  assign signed_pp = sel_neg ? (~mag + 16'd1) : mag;
  assign pp        = signed_pp << {idx, 1'b0};
endmodule

// File: rtl/booth_mult_seq.sv
// Iterative 8x8 radix-4 Booth multiplier: accept, 5 digit-add cycles, present product.
// Latency 5 clocks from accept edge to out_valid; 1 result per 7 cycles peak.
// DONE holds product and out_valid until out_ready; in_ready only in IDLE outside reset.
module booth_mult_seq
  import booth_mult_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPERAND_W-1:0] multiplicand,
  input  logic [OPERAND_W-1:0] multiplier,
  input  logic                 signed_mcand,
  input  logic                 signed_mpy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PRODUCT_W-1:0] product,
  output logic                 busy
);
  state_t                  state;
  logic [OPERAND_W-1:0]    mcand_q;
  logic [OPERAND_W-1:0]    mpy_q;
  logic                    smc_q;
  logic                    smp_q;
  logic [IDX_W-1:0]        idx;
  logic [PRODUCT_W-1:0]    acc;
  logic [PRODUCT_W-1:0]    m_ext;
  logic [PRODUCT_W-1:0]    pp;
  logic [PRODUCT_W-1:0]    acc_next;
  logic [BOOTH_DIGITS-1:0] dig_single;
  logic [BOOTH_DIGITS-1:0] dig_double;
  logic [BOOTH_DIGITS-1:0] dig_neg;

  assign m_ext    = {{(PRODUCT_W-OPERAND_W){smc_q & mcand_q[OPERAND_W-1]}}, mcand_q};
  assign acc_next = acc + pp;
  assign in_ready = (state == ST_IDLE) && !rst;

  booth_encoder u_enc (
    .multiplier (mpy_q),
    .signed_mpy (smp_q),
    .sel_single (dig_single),
    .sel_double (dig_double),
    .sel_neg    (dig_neg)
  );

  booth_pp_gen u_pp (
    .m          (m_ext),
    .sel_single (dig_single[idx]),
    .sel_double (dig_double[idx]),
    .sel_neg    (dig_neg[idx]),
    .idx        (idx),
    .pp         (pp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      product   <= '0;
      idx       <= '0;
      acc       <= '0;
      mcand_q   <= '0;
      mpy_q     <= '0;
      smc_q     <= 1'b0;
      smp_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            mcand_q <= multiplicand;
            mpy_q   <= multiplier;
            smc_q   <= signed_mcand;
            smp_q   <= signed_mpy;
            acc     <= '0;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc <= acc_next;
          idx <= idx + 3'd1;
          if (idx == IDX_W'(BOOTH_DIGITS - 1)) begin
            product   <= acc_next;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq with hand-computed products and handshake timing checks.
module tb_booth_mult_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic        signed_mcand;
  logic        signed_mpy;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;

  int tests = 0;
  int fails = 0;

  booth_mult_seq dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .signed_mcand (signed_mcand),
    .signed_mpy   (signed_mpy),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand pair at the next edge, then count edges until out_valid.
  task automatic start_and_wait(input logic [7:0] a, input logic [7:0] b,
                                input logic sa, input logic sb, input bit scramble,
                                output int lat);
    multiplicand = a;
    multiplier   = b;
    signed_mcand = sa;
    signed_mpy   = sb;
    in_valid     = 1'b1;
    check("accept_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    if (scramble) begin
      multiplicand = 8'h00;
      multiplier   = 8'h00;
      signed_mcand = ~sa;
      signed_mpy   = ~sb;
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic sa, input logic sb, input bit scramble,
                        input logic [15:0] exp);
    int lat;
    start_and_wait(a, b, sa, sb, scramble, lat);
    check({tag, "_latency"}, lat, 5);
    check({tag, "_product"}, product, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_released"}, {out_valid, busy, in_ready}, 3'b001);
    check({tag, "_product_kept"}, product, exp);
  endtask

  initial begin
    int lat;
    logic [15:0] held;
    rst          = 1'b1;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    multiplicand = 8'h00;
    multiplier   = 8'h00;
    signed_mcand = 1'b0;
    signed_mpy   = 1'b0;
    tick();
    tick();
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_product", product, 16'h0000);
    check("reset_busy", busy, 1'b0);
    check("reset_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    check("post_reset_in_ready", in_ready, 1'b1);

    run_op("uns_ff_ff", 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 16'hFE01);
    run_op("sgn_80_80", 8'h80, 8'h80, 1'b1, 1'b1, 1'b0, 16'h4000);
    run_op("mix_80_ff", 8'h80, 8'hFF, 1'b1, 1'b0, 1'b0, 16'h8080);
    run_op("sgn_7f_81", 8'h7F, 8'h81, 1'b1, 1'b1, 1'b1, 16'hC0FF);
    run_op("mix_ff_ff", 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 16'hFF01);

    // Backpressure: out_ready low for 10 cycles while a new pair is offered.
    start_and_wait(8'h12, 8'h34, 1'b0, 1'b0, 1'b0, lat);
    check("bp_latency", lat, 5);
    check("bp_product", product, 16'h03A8);
    held         = product;
    multiplicand = 8'h0A;
    multiplier   = 8'h0B;
    in_valid     = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_product", product, held);
      check("bp_hold_flags", {out_valid, busy, in_ready}, 3'b110);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_idle_flags", {out_valid, busy, in_ready}, 3'b001);
    tick();
    in_valid = 1'b0;
    check("bp_next_accept", {busy, in_ready}, 2'b10);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("bp_next_latency", lat, 5);
    check("bp_next_product", product, 16'h006E);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset asserted across RUN edge E3 aborts the operation.
    multiplicand = 8'hFF;
    multiplier   = 8'hFF;
    signed_mcand = 1'b0;
    signed_mpy   = 1'b0;
    in_valid     = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_product", product, 16'h0000);
    check("abort_busy", busy, 1'b0);
    check("abort_in_ready", in_ready, 1'b1);
    run_op("uns_3_5", 8'h03, 8'h05, 1'b0, 1'b0, 1'b0, 16'h000F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
